// File: rtl/i2si_ctrl.sv
// I2S input-path sequencer: settles on a live bit clock, gates the deserializer, drains the
// FIFO on mode changes, flags bit-clock loss, and counts frames and FIFO overruns.
module i2si_ctrl #(
  parameter int unsigned SETTLE_EDGES  = 4,
  parameter int unsigned SCK_TIMEOUT   = 1024,
  parameter int unsigned DRAIN_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rf_cfg_en,
  input  logic        rf_cfg_mode,
  input  logic        rf_auto_clr,
  input  logic        sync_sck,
  input  logic        i2si_rts,
  input  logic        i2si_rtr,
  input  logic        ro_fifo_overrun,
  input  logic        trig_sck_lost_clr,
  output logic        ctrl_i2si_en,
  output logic        ctrl_mux_en,
  output logic        trig_fifo_overrun_clr,
  output logic [2:0]  ro_state,
  output logic        ro_sck_lost,
  output logic [15:0] ro_frame_cnt,
  output logic [7:0]  ro_overrun_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] FAULT  = 3'd4;

  localparam int unsigned WW = $clog2(SCK_TIMEOUT + 1);
  localparam int unsigned EW = $clog2(SETTLE_EDGES + 1);
  localparam int unsigned DW = $clog2(DRAIN_TIMEOUT + 1);

  logic [2:0]    state_q, state_d;
  logic          sck_q, rise;
  logic [WW-1:0] wd_q;
  logic          wd_active, wd_expired;
  logic [EW-1:0] edge_q;
  logic [DW-1:0] drain_q;
  logic          ovr_q, ovr_rise;
  logic          en_q, mux_q, clr_q, lost_q;
  logic [15:0]   frame_q;
  logic [7:0]    ovr_cnt_q;

  always_comb begin
    rise       = sync_sck & ~sck_q;
    ovr_rise   = ro_fifo_overrun & ~ovr_q;
    wd_active  = (state_q == SETTLE) || (state_q == RUN);
    wd_expired = wd_active && (wd_q == WW'(SCK_TIMEOUT));
  end

  // Clock-loss timeout outranks every other exit from SETTLE and RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (rf_cfg_en) state_d = SETTLE;
      SETTLE: begin
        if (wd_expired)                                        state_d = FAULT;
        else if (!rf_cfg_en)                                   state_d = IDLE;
        else if (rise && (edge_q == EW'(SETTLE_EDGES - 1)))    state_d = RUN;
      end
      RUN: begin
        if (wd_expired)                                        state_d = FAULT;
        else if (!rf_cfg_en || (rf_cfg_mode != mux_q))         state_d = DRAIN;
      end
      DRAIN:  if (!i2si_rts || (drain_q == DW'(DRAIN_TIMEOUT - 1))) state_d = IDLE;
      FAULT:  if (!rf_cfg_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sck_q     <= 1'b0;
      wd_q      <= '0;
      edge_q    <= '0;
      drain_q   <= '0;
      ovr_q     <= 1'b0;
      en_q      <= 1'b0;
      mux_q     <= 1'b0;
      clr_q     <= 1'b0;
      lost_q    <= 1'b0;
      frame_q   <= '0;
      ovr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sck_q   <= sync_sck;
      ovr_q   <= ro_fifo_overrun;

      if (!wd_active || rise)            wd_q <= '0;
      else if (wd_q != WW'(SCK_TIMEOUT)) wd_q <= wd_q + 1'b1;

      if (state_q == IDLE)               edge_q <= '0;
      else if (state_q == SETTLE && rise) edge_q <= edge_q + 1'b1;

      drain_q <= (state_q == DRAIN) ? drain_q + 1'b1 : '0;

      // High only while remaining in RUN, so it rises the cycle after entry.
      en_q <= (state_q == RUN) && (state_d == RUN);

      if (state_q == IDLE && rf_cfg_en) begin
        mux_q   <= rf_cfg_mode;
        frame_q <= '0;
      end else if ((state_q == RUN || state_q == DRAIN) && i2si_rts && i2si_rtr) begin
        frame_q <= frame_q + 1'b1;
      end

      if (state_d == FAULT && state_q != FAULT) lost_q <= 1'b1;
      else if (trig_sck_lost_clr)               lost_q <= 1'b0;

      if (ovr_rise && ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 1'b1;
      clr_q <= ovr_rise & rf_auto_clr;
    end
  end

  assign ctrl_i2si_en          = en_q;
  assign ctrl_mux_en           = mux_q;
  assign trig_fifo_overrun_clr = clr_q;
  assign ro_state              = state_q;
  assign ro_sck_lost           = lost_q;
  assign ro_frame_cnt          = frame_q;
  assign ro_overrun_cnt        = ovr_cnt_q;

endmodule

// File: tb/tb_i2si_ctrl.sv
// Directed bench for i2si_ctrl: settle, frame counting and wrap, drain paths, clock loss,
// overrun counting with auto-clear, and mid-run reset.
module tb_i2si_ctrl;

  logic        clk = 1'b0;
  logic        rst, rf_cfg_en, rf_cfg_mode, rf_auto_clr, sync_sck;
  logic        i2si_rts, i2si_rtr, ro_fifo_overrun, trig_sck_lost_clr;
  logic        ctrl_i2si_en, ctrl_mux_en, trig_fifo_overrun_clr, ro_sck_lost;
  logic [2:0]  ro_state;
  logic [15:0] ro_frame_cnt;
  logic [7:0]  ro_overrun_cnt;

  int checks = 0;
  int failures = 0;
  logic sck_run = 1'b0;
  int sck_ph = 0;

  i2si_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .rf_cfg_en             (rf_cfg_en),
    .rf_cfg_mode           (rf_cfg_mode),
    .rf_auto_clr           (rf_auto_clr),
    .sync_sck              (sync_sck),
    .i2si_rts              (i2si_rts),
    .i2si_rtr              (i2si_rtr),
    .ro_fifo_overrun       (ro_fifo_overrun),
    .trig_sck_lost_clr     (trig_sck_lost_clr),
    .ctrl_i2si_en          (ctrl_i2si_en),
    .ctrl_mux_en           (ctrl_mux_en),
    .trig_fifo_overrun_clr (trig_fifo_overrun_clr),
    .ro_state              (ro_state),
    .ro_sck_lost           (ro_sck_lost),
    .ro_frame_cnt          (ro_frame_cnt),
    .ro_overrun_cnt        (ro_overrun_cnt)
  );

  always #5 clk = ~clk;

  // Bit clock with a period of 8 clk cycles while sck_run is set.
  initial begin
    sync_sck = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (sck_run) begin
        sck_ph++;
        if (sck_ph == 4) begin
          sck_ph = 0;
          sync_sck = ~sync_sck;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int limit, input string tag);
    int n = 0;
    while (ro_state !== target && n < limit) begin
      tick();
      n++;
    end
    chk(tag, 32'(ro_state), 32'(target));
  endtask

  initial begin
    rst = 1'b1; rf_cfg_en = 1'b0; rf_cfg_mode = 1'b0; rf_auto_clr = 1'b0;
    i2si_rts = 1'b0; i2si_rtr = 1'b0; ro_fifo_overrun = 1'b0; trig_sck_lost_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_state", 32'(ro_state), 32'd0);
    chk("reset_en", 32'(ctrl_i2si_en), 32'd0);
    chk("reset_mux", 32'(ctrl_mux_en), 32'd0);
    chk("reset_frames", 32'(ro_frame_cnt), 32'd0);
    chk("reset_ovr", 32'(ro_overrun_cnt), 32'd0);
    chk("reset_lost", 32'(ro_sck_lost), 32'd0);

    // Settle on four rises, then RUN with enable one cycle later.
    rf_cfg_en = 1'b1; sck_run = 1'b1;
    tick();
    chk("enter_settle", 32'(ro_state), 32'd1);
    wait_state(3'd2, 100, "reach_run");
    chk("en_at_run_entry", 32'(ctrl_i2si_en), 32'd0);
    tick();
    chk("en_after_run", 32'(ctrl_i2si_en), 32'd1);
    chk("mux_live", 32'(ctrl_mux_en), 32'd0);

    // Five accepted frames, then wrap through 0xFFFF.
    i2si_rts = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i2si_rtr = 1'b1; tick();
      i2si_rtr = 1'b0; tick();
    end
    chk("frames_5", 32'(ro_frame_cnt), 32'd5);
    i2si_rtr = 1'b1;
    repeat (65530) tick();
    chk("frames_ffff", 32'(ro_frame_cnt), 32'hFFFF);
    tick();
    chk("frames_wrap", 32'(ro_frame_cnt), 32'd0);
    i2si_rtr = 1'b0;

    // Mode switch: 10 cycles of DRAIN, one IDLE, then SETTLE in BIST mode.
    rf_cfg_mode = 1'b1;
    tick();
    chk("drain_entry", 32'(ro_state), 32'd3);
    chk("drain_en_off", 32'(ctrl_i2si_en), 32'd0);
    repeat (9) tick();
    chk("drain_10th", 32'(ro_state), 32'd3);
    i2si_rts = 1'b0;
    tick();
    chk("drain_to_idle", 32'(ro_state), 32'd0);
    tick();
    chk("resettle", 32'(ro_state), 32'd1);
    chk("mux_bist", 32'(ctrl_mux_en), 32'd1);

    // Drain with rts stuck high times out after 256 cycles.
    wait_state(3'd2, 100, "run_bist");
    i2si_rts = 1'b1; rf_cfg_mode = 1'b0;
    tick();
    chk("drain2_entry", 32'(ro_state), 32'd3);
    repeat (255) tick();
    chk("drain2_256th", 32'(ro_state), 32'd3);
    tick();
    chk("drain2_timeout", 32'(ro_state), 32'd0);
    i2si_rts = 1'b0;

    // Bit-clock loss.
    wait_state(3'd2, 100, "run_live");
    sck_run = 1'b0;
    repeat (900) tick();
    chk("no_fault_yet", 32'(ro_state), 32'd2);
    wait_state(3'd4, 300, "fault");
    chk("lost_set", 32'(ro_sck_lost), 32'd1);
    chk("fault_en_off", 32'(ctrl_i2si_en), 32'd0);
    rf_cfg_en = 1'b0;
    tick();
    chk("fault_exit", 32'(ro_state), 32'd0);
    chk("lost_sticky", 32'(ro_sck_lost), 32'd1);
    trig_sck_lost_clr = 1'b1; tick(); trig_sck_lost_clr = 1'b0;
    chk("lost_cleared", 32'(ro_sck_lost), 32'd0);

    // Overruns with auto-clear pulses, then saturation.
    rf_auto_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ro_fifo_overrun = 1'b1; tick();
      chk("clr_pulse_hi", 32'(trig_fifo_overrun_clr), 32'd1);
      ro_fifo_overrun = 1'b0; tick();
      chk("clr_pulse_lo", 32'(trig_fifo_overrun_clr), 32'd0);
    end
    chk("ovr_cnt_3", 32'(ro_overrun_cnt), 32'd3);
    rf_auto_clr = 1'b0;
    ro_fifo_overrun = 1'b1; tick();
    chk("no_auto_clr", 32'(trig_fifo_overrun_clr), 32'd0);
    chk("ovr_cnt_4", 32'(ro_overrun_cnt), 32'd4);
    ro_fifo_overrun = 1'b0; tick();
    for (int i = 0; i < 300; i++) begin
      ro_fifo_overrun = 1'b1; tick();
      ro_fifo_overrun = 1'b0; tick();
    end
    chk("ovr_sat", 32'(ro_overrun_cnt), 32'd255);

    // Reset while running in BIST mode.
    rf_cfg_en = 1'b1; rf_cfg_mode = 1'b1; sck_run = 1'b1;
    wait_state(3'd2, 100, "run_before_rst");
    i2si_rts = 1'b1; i2si_rtr = 1'b1;
    tick();
    chk("en_before_rst", 32'(ctrl_i2si_en), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_state", 32'(ro_state), 32'd0);
    chk("rst_en", 32'(ctrl_i2si_en), 32'd0);
    chk("rst_mux", 32'(ctrl_mux_en), 32'd0);
    chk("rst_frames", 32'(ro_frame_cnt), 32'd0);
    chk("rst_ovr", 32'(ro_overrun_cnt), 32'd0);
    chk("rst_clr", 32'(trig_fifo_overrun_clr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2si_ctrl.md
Name: i2si_ctrl

Overview:
Sequencer for the I2S input path. Owns deserializer enable and BIST/live mux select, and switches modes safely: it settles on a running bit clock, drains the FIFO, and watches for bit-clock loss. It also counts delivered frames and overruns, and auto-clears the overrun flag. It sits between the register file and the i2s_in block: register-file config goes in, i2si_en/mux_en/overrun_clr come out.

Parameters:
SETTLE_EDGES, 4, rising sync_sck edges required before enabling capture
SCK_TIMEOUT, 1024, clk cycles without a sync_sck rising edge that declare clock loss
DRAIN_TIMEOUT, 256, max clk cycles spent draining the FIFO

Ports:
clk  input  1  master clock
rst  input  1  synchronous reset, active-high
rf_cfg_en  input  1  software enable for the input path
rf_cfg_mode  input  1  0 = live deserializer, 1 = BIST
rf_auto_clr  input  1  1 = auto-pulse overrun clear
sync_sck  input  1  synchronized bit clock from i2s_in
i2si_rts  input  1  FIFO output not-empty
i2si_rtr  input  1  consumer ready
ro_fifo_overrun  input  1  overrun flag from i2s_in
trig_sck_lost_clr  input  1  clears ro_sck_lost
ctrl_i2si_en  output  1  deserializer enable
ctrl_mux_en  output  1  mux select (BIST when 1)
trig_fifo_overrun_clr  output  1  one-cycle overrun clear pulse
ro_state  output  3  current FSM state encoding
ro_sck_lost  output  1  sticky bit-clock-loss flag
ro_frame_cnt  output  16  frames accepted by consumer since last SETTLE
ro_overrun_cnt  output  8  overrun events, saturating

Behaviour:
- Reset values: state IDLE (3'd0); all outputs 0; internal counters 0.
- Edge detect: sck_q registers sync_sck. rise = sync_sck & ~sck_q.
- Watchdog counter: cleared on rise, otherwise increments and saturates at SCK_TIMEOUT. It is active in SETTLE and RUN only and is held at 0 elsewhere.
- State encoding: IDLE=0, SETTLE=1, RUN=2, DRAIN=3, FAULT=4.
- IDLE:
  - ctrl_i2si_en=0.
  - If rf_cfg_en=1: latch ctrl_mux_en<=rf_cfg_mode, clear ro_frame_cnt, clear the edge counter, go to SETTLE.
  - ctrl_mux_en changes only on this transition.
- SETTLE:
  - Counts rises.
  - On the SETTLE_EDGES-th rise, go to RUN.
  - rf_cfg_en=0 returns to IDLE.
  - Watchdog reaching SCK_TIMEOUT goes to FAULT; this has priority over cfg_en.
- RUN:
  - ctrl_i2si_en=1 (registered; asserted the cycle after entry).
  - If rf_cfg_en=0 or rf_cfg_mode != ctrl_mux_en, go to DRAIN.
  - Watchdog timeout goes to FAULT and has priority.
- DRAIN:
  - ctrl_i2si_en=0.
  - A drain counter increments each cycle.
  - Go to IDLE when i2si_rts=0 or the counter reaches DRAIN_TIMEOUT-1.
  - If cfg_en is still 1, IDLE immediately re-enters SETTLE with the new mode (a mode switch costs at least 2 cycles plus settle).
- FAULT:
  - ctrl_i2si_en=0 and ro_sck_lost<=1.
  - Exit to IDLE only when rf_cfg_en=0.
- ro_sck_lost:
  - Set on FAULT entry.
  - Cleared by trig_sck_lost_clr.
  - Set wins if both happen in the same cycle.
- ro_frame_cnt:
  - Increments when i2si_rts & i2si_rtr in RUN or DRAIN.
  - 16-bit, wraps 0xFFFF->0.
  - Cleared on SETTLE entry.
- Overrun handling:
  - Register ovr_q tracks ro_fifo_overrun.
  - Rising edge increments ro_overrun_cnt, saturating at 255.
  - If rf_auto_clr=1, trig_fifo_overrun_clr pulses high for exactly one cycle, one cycle after the detected edge.
  - This logic is independent of state.
- Synchronous reset mid-operation forces IDLE next edge and drops ctrl_i2si_en immediately after that edge.

Test Plan:
- Reset, cfg_en=1, mode=0, sck period 8 clk -> SETTLE for 4 rises, then RUN; ctrl_i2si_en=1 the cycle after RUN entry; ctrl_mux_en=0.
- RUN, consumer accepts 5 frames (rts&rtr pulses) -> ro_frame_cnt=5; preload 0xFFFF plus 1 accept -> 0x0000.
- RUN, toggle mode to 1 with rts=1 held, drained after 10 cycles -> DRAIN 10 cycles, IDLE 1 cycle, SETTLE with ctrl_mux_en=1; drain with rts stuck 1 -> exits after 256 cycles.
- RUN, stop sck for 1024 cycles -> FAULT, ro_sck_lost=1, ctrl_i2si_en=0; cfg_en=0 -> IDLE; trig_sck_lost_clr -> flag 0.
- rf_auto_clr=1, raise ro_fifo_overrun 3 times -> ro_overrun_cnt=3, three single-cycle clr pulses; 300 edges -> count stays 255.
- rst asserted in RUN -> next edge state=0, all outputs 0.
